// File: rtl/data_mem_lsu_if.sv
`default_nettype none
// ============================================================================
// data_mem_lsu_if : request/response bus between a core and data_mem_lsu
// Revision 1.0
// ============================================================================
interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
// data_mem_lsu : byte-addressed little-endian data memory with RV32 load/store
//                sizing, optional two-beat misaligned access. Revision 1.0
// ============================================================================
module data_mem_lsu #(
    parameter int DATA_BYTES  = 128,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    data_mem_lsu_if.slave bus
);
    localparam int AW = $clog2(DATA_BYTES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT2 = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]    state;
    logic [7:0]    mem [DATA_BYTES];

    logic [AW-1:0] saved_addr;
    logic [2:0]    saved_funct3;
    logic          saved_we;
    logic [31:0]   saved_wdata;
    logic [31:0]   load_bytes;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic          in_beat2;
    logic [AW-1:0] cur_addr;
    logic [2:0]    cur_funct3;
    logic          cur_we;
    logic [31:0]   cur_wdata;
    logic [2:0]    nbytes;
    logic          illegal;
    logic          crosses;
    logic          reject;
    logic          wr_en;
    logic [AW-1:0] byte_addr [4];
    logic [3:0]    byte_en;
    logic [31:0]   bytes_next;
    logic [31:0]   final_rdata;
    logic          unused_addr_bits;

    assign bus.req_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign unused_addr_bits = ^bus.req_addr[31:AW];

    assign accept   = bus.req_valid && bus.req_ready;
    assign in_beat2 = (state == BEAT2);

    // The second beat replays the saved request so one byte datapath serves both beats.
    assign cur_addr   = in_beat2 ? saved_addr   : bus.req_addr[AW-1:0];
    assign cur_funct3 = in_beat2 ? saved_funct3 : bus.req_funct3;
    assign cur_we     = in_beat2 ? saved_we     : bus.req_we;
    assign cur_wdata  = in_beat2 ? saved_wdata  : bus.req_wdata;

    always_comb begin
        case (cur_funct3[1:0])
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign illegal = (cur_funct3 == 3'b011) || (cur_funct3[2:1] == 2'b11) ||
                     (cur_we && cur_funct3[2]);
    assign crosses = ({1'b0, cur_addr[1:0]} + nbytes) > 3'd4;
    assign reject  = illegal || (crosses && !MISALIGN_EN);
    assign wr_en   = !reset && cur_we && ((accept && !reject) || in_beat2);

    // Bytes inside the first word belong to beat one, the rest to beat two.
    always_comb begin
        byte_en    = 4'b0000;
        bytes_next = 32'h0;
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = cur_addr + AW'(k);
            byte_en[k]   = (3'(k) < nbytes) &&
                           ((({1'b0, cur_addr[1:0]} + 3'(k)) < 3'd4) != in_beat2);
            if (byte_en[k])
                bytes_next[8*k +: 8] = mem[byte_addr[k]];
            else if (in_beat2)
                bytes_next[8*k +: 8] = load_bytes[8*k +: 8];
        end
    end

    always_comb begin
        final_rdata = 32'h0;
        if (!cur_we) begin
            case (cur_funct3)
                3'b000:  final_rdata = {{24{bytes_next[7]}}, bytes_next[7:0]};
                3'b001:  final_rdata = {{16{bytes_next[15]}}, bytes_next[15:0]};
                3'b010:  final_rdata = bytes_next;
                3'b100:  final_rdata = {24'h0, bytes_next[7:0]};
                3'b101:  final_rdata = {16'h0, bytes_next[15:0]};
                default: final_rdata = 32'h0;
            endcase
        end
    end

    // Memory has no reset so contents survive it.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en && byte_en[k])
                mem[byte_addr[k]] <= cur_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            saved_addr   <= bus.req_addr[AW-1:0];
            saved_funct3 <= bus.req_funct3;
            saved_we     <= bus.req_we;
            saved_wdata  <= bus.req_wdata;
            if (reject) begin
                state   <= RESP;
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end else if (crosses) begin
                state      <= BEAT2;
                load_bytes <= bytes_next;
            end else begin
                state   <= RESP;
                rdata_q <= final_rdata;
                err_q   <= 1'b0;
            end
        end else if (in_beat2) begin
            state   <= RESP;
            rdata_q <= final_rdata;
            err_q   <= 1'b0;
        end else if ((state == RESP) && bus.rsp_ready) begin
            state <= IDLE;
        end
    end
endmodule
`default_nettype wire

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter DATA_BYTES, 128, data memory size in bytes; power of two, >= 8.
REQ-002 Parameter MISALIGN_EN, 1, 1 = halfword/word accesses crossing a word boundary are split into two beats; 0 = such accesses are rejected with rsp_err.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted on the edge where req_valid && req_ready.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32 size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data; low bytes used for sb/sh.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  response consumed on the edge where rsp_valid && rsp_ready.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  illegal funct3 or rejected misaligned access.

Function
REQ-015 Storage shall be DATA_BYTES bytes, little-endian: byte k of a word at address A is at A+k.
REQ-016 Every byte address shall be taken modulo DATA_BYTES, including the individual bytes of a split access.
REQ-017 State machine states: IDLE, BEAT2, RESP.
REQ-018 req_ready shall be 1 in IDLE, 1 in RESP when rsp_ready=1, and 0 otherwise.
REQ-019 For an aligned or byte request accepted at edge N, the state shall be RESP after edge N, with rsp_valid=1 from that point.
REQ-020 For a boundary-crossing request with MISALIGN_EN=1, the first word shall be accessed at edge N and the second at edge N+1 (state BEAT2 in between), with rsp_valid=1 after edge N+1.
REQ-021 Stores shall write only the addressed bytes: 1 byte for b, 2 for h, 4 for w; a split store shall write its low-address bytes at edge N and the remaining bytes at edge N+1.
REQ-022 lb/lh shall sign-extend to 32 bits; lbu/hu shall zero-extend.
REQ-023 funct3 011, 110, 111, or funct3 with req_we=1 outside {000, 001, 010}, shall give a response with rsp_err=1, rsp_rdata=0, no memory write, and latency 1.
REQ-024 A boundary-crossing h/w access with MISALIGN_EN=0 shall be handled as in REQ-023.
REQ-025 While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err shall hold stable and no request shall be accepted.
REQ-026 In RESP with rsp_ready=1 and req_valid=1, the response shall retire and the new request shall be accepted on the same edge, giving 1 aligned access per cycle.
REQ-027 In RESP with rsp_ready=1 and req_valid=0, the state shall return to IDLE.
REQ-028 A load following a store to the same bytes shall return the stored data.

Reset
REQ-029 With reset=1 at a rising edge: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; req_ready = 1 on the following cycle.
REQ-030 Memory contents shall not be changed by reset.
REQ-031 If reset occurs in BEAT2, the second-beat bytes shall not be written, bytes written at edge N shall remain, and no response shall be produced.

Verification
REQ-032 sw 0x0000_0003 to addr 4, then lw from addr 4 -> rsp_rdata=0x0000_0003, rsp_valid one cycle after acceptance, rsp_err=0.
REQ-033 With mem[4..7]=8f,77,77,77: lb addr 4 -> 0xffff_ff8f; lbu addr 4 -> 0x0000_008f; with mem[4..5]=8f,8f, lhu addr 4 -> 0x0000_8f8f.
REQ-034 With mem[4..7]=8f,8f,77,77, sh 0x9999_9999 at addr 4 -> mem[4..7]=99,99,77,77.
REQ-035 With DATA_BYTES=128 and mem[0..3]=7f,7f,f7,f7, lw addr 128 -> 0xf7f7_7f7f; with mem[124..127]=88, lw addr 124 -> 0x8888_8888.
REQ-036 With MISALIGN_EN=1 and mem[126,127,0,1]=11,22,33,44, lw addr 126 -> 0x4433_2211 with latency 2; with MISALIGN_EN=0 the same request -> rsp_err=1, rsp_rdata=0.
REQ-037 Three back-to-back aligned lw with rsp_ready held low for 3 cycles after the first response -> first response held stable, req_ready=0 during the hold, all three responses returned in order with no loss.
